neighbor_cam_table: RTL and testbench
=====================================

NEIGHBOR_CAM_TABLE -- requirements
Module: neighbor_cam_table

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, width of every neighbor field.
REQ-002 SHALL have parameter DEPTH, default 32, number of entries (power of two, 4..256).
REQ-003 SHALL have parameter MY_NODE_ID, default 16'h000C, own node ID; writes carrying it are ignored.
REQ-004 SHALL have ports clk, in, 1, sole clock; rst, in, 1, asynchronous active-high reset.
REQ-005 SHALL have ports wr_en (in, 1, write request) and hb_reset (in, 1, heartbeat clear request).
REQ-006 SHALL have input ports node_id, node_hops, node_qvalue, node_energy and node_chhops, each WORD_WIDTH wide, carrying the write payload.
REQ-007 SHALL have rd_idx, in, $clog2(DEPTH), read address.
REQ-008 SHALL have output ports rd_id, rd_hops, rd_qvalue, rd_energy and rd_chhops, each WORD_WIDTH wide, plus rd_valid (out, 1), giving the entry at rd_idx.
REQ-009 SHALL have busy, out, 1, high when not in IDLE.
REQ-010 SHALL have wr_done and wr_drop, out, 1 each, single-cycle result pulses.
REQ-011 SHALL have count, out, $clog2(DEPTH+1), number of valid entries; full, out, 1, count==DEPTH.

Function
REQ-012 SHALL implement FSM IDLE, SEARCH, WRITE, CLEAR.
REQ-013 SHALL, in IDLE with wr_en=1, hb_reset=0 and node_id!=MY_NODE_ID, latch all five payload fields, set scan index to 0 and enter SEARCH.
REQ-014 SHALL ignore wr_en while busy=1 and also when node_id==MY_NODE_ID, with no pulse and no state change.
REQ-015 SHALL examine one entry per SEARCH cycle, ascending from index 0, recording the lowest free index seen.
REQ-016 SHALL, on a valid entry whose ID equals the latched ID, select that index as the hit and enter WRITE the next cycle (early exit).
REQ-017 SHALL, after index DEPTH-1 with no hit, select the lowest free index (insert) and enter WRITE; if there is none, apply REQ-027/REQ-028.
REQ-018 SHALL, in WRITE, store all fields at the selected index, set its valid bit, increment count only on insert, pulse wr_done, and return to IDLE.
REQ-019 SHALL keep write latency at hit-index+2 cycles from acceptance to wr_done, and DEPTH+1 cycles for an insert.
REQ-020 SHALL, on hb_reset=1 in any state, abandon any pending write without a pulse and enter CLEAR next cycle.
REQ-021 SHALL, in CLEAR, zero all valid bits and count, and return to IDLE; data fields are retained.
REQ-022 SHALL let hb_reset win when wr_en and hb_reset are simultaneous in IDLE, discarding the write.
REQ-023 SHALL drive read outputs combinationally from rd_idx, with zero latency.
REQ-024 SHALL force every rd_* output to 0 when the entry is invalid.
REQ-025 SHALL return the newly written values from the cycle after WRITE.

Reset
REQ-026 SHALL, on rst=1, immediately set state to IDLE; clear all valid bits, count, full, busy, wr_done, wr_drop and all stored fields; and force read outputs to 0.

Configuration
REQ-027 SHALL, with NEIGHBOR_EVICT_EN defined, track during SEARCH the valid entry with the lowest node_energy (lowest index on ties); on a full-table miss it SHALL overwrite that entry, pulse wr_done and leave count unchanged.
REQ-028 SHALL, without NEIGHBOR_EVICT_EN, on a full-table miss leave the table unchanged, pulse wr_drop, and return to IDLE after DEPTH+1 cycles.

Verification
REQ-029 SHALL cover: reset, then write ID 0x0003 -> wr_done 33 cycles later at DEPTH=32, index 0 valid, count=1.
REQ-030 SHALL cover: rewrite ID 0x0003 with hops=5 -> wr_done 2 cycles after acceptance, index 0 hops=5, count stays 1.
REQ-031 SHALL cover: write ID 0x000C -> busy stays 0, no pulse, table unchanged.
REQ-032 SHALL cover: fill 32 IDs with energies 100..131, then write new ID 0x0050 -> wr_drop without the macro; with NEIGHBOR_EVICT_EN, the energy-100 entry is replaced and count=32.
REQ-033 SHALL cover: hb_reset asserted mid-SEARCH -> CLEAR next cycle, then count=0, all rd_valid=0, no wr_done.
REQ-034 SHALL cover: rst asserted mid-WRITE -> outputs zero immediately, busy=0.

Source files
------------

// File: rtl/neighbor_cam_table.sv
// rtl/neighbor_cam_table.sv - neighbor table with serial associative search
//
// Holds up to DEPTH neighbor records (id, hops, qvalue, energy, chhops).
// A write is searched one entry per cycle: a matching valid ID is updated
// in place (early exit); otherwise the lowest free slot is filled.  On a
// full-table miss the write is dropped (wr_drop), or, when the macro
// NEIGHBOR_EVICT_EN is defined, the valid entry with the lowest energy
// (lowest index on ties) is overwritten.  hb_reset invalidates the table.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en, node_*       write request and payload (ignored while busy or
//                       when node_id == MY_NODE_ID)
//   hb_reset            heartbeat clear; wins over any write
//   rd_idx, rd_*        combinational read port, zero when entry invalid
//   busy                FSM not idle
//   wr_done, wr_drop    one-cycle write result pulses
//   count, full         number of valid entries, count == DEPTH
module neighbor_cam_table #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH = 32,
  parameter logic [WORD_WIDTH-1:0] MY_NODE_ID = WORD_WIDTH'(16'h000C)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         hb_reset,
  input  logic [WORD_WIDTH-1:0]        node_id,
  input  logic [WORD_WIDTH-1:0]        node_hops,
  input  logic [WORD_WIDTH-1:0]        node_qvalue,
  input  logic [WORD_WIDTH-1:0]        node_energy,
  input  logic [WORD_WIDTH-1:0]        node_chhops,
  input  logic [$clog2(DEPTH)-1:0]     rd_idx,
  output logic [WORD_WIDTH-1:0]        rd_id,
  output logic [WORD_WIDTH-1:0]        rd_hops,
  output logic [WORD_WIDTH-1:0]        rd_qvalue,
  output logic [WORD_WIDTH-1:0]        rd_energy,
  output logic [WORD_WIDTH-1:0]        rd_chhops,
  output logic                         rd_valid,
  output logic                         busy,
  output logic                         wr_done,
  output logic                         wr_drop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, SEARCH, WRITE, CLEAR} state_t;
  state_t state, state_nx;

  logic [WORD_WIDTH-1:0] id_mem     [DEPTH];
  logic [WORD_WIDTH-1:0] hops_mem   [DEPTH];
  logic [WORD_WIDTH-1:0] qvalue_mem [DEPTH];
  logic [WORD_WIDTH-1:0] energy_mem [DEPTH];
  logic [WORD_WIDTH-1:0] chhops_mem [DEPTH];
  logic [DEPTH-1:0]      valid;

  logic [WORD_WIDTH-1:0] lat_id, lat_hops, lat_qvalue, lat_energy, lat_chhops;
  logic [AW-1:0]         scan;
  logic [AW-1:0]         sel;
  logic                  sel_insert;
  logic                  sel_drop;
  logic                  free_found;
  logic [AW-1:0]         free_idx;

  logic                  accept;
  logic                  hit_now;
  logic                  last_now;
  logic                  nxt_free_found;
  logic [AW-1:0]         nxt_free_idx;

`ifdef NEIGHBOR_EVICT_EN
  logic                  ev_found;
  logic [AW-1:0]         ev_idx;
  logic [WORD_WIDTH-1:0] ev_energy;
  logic                  ev_better;
  logic [AW-1:0]         nxt_ev_idx;
  logic [WORD_WIDTH-1:0] nxt_ev_energy;
`endif

  assign accept   = wr_en && (node_id != MY_NODE_ID);
  assign hit_now  = valid[scan] && (id_mem[scan] == lat_id);
  assign last_now = (scan == AW'(DEPTH-1));

  // Trackers including the entry under examination this cycle, so the
  // final decision at the last index already accounts for that entry.
  always_comb begin
    nxt_free_found = free_found | ~valid[scan];
    nxt_free_idx   = free_found ? free_idx : scan;
  end

`ifdef NEIGHBOR_EVICT_EN
  // Strict less-than keeps the lowest index among equal energies.
  always_comb begin
    ev_better     = valid[scan] && (!ev_found || (energy_mem[scan] < ev_energy));
    nxt_ev_idx    = ev_better ? scan : ev_idx;
    nxt_ev_energy = ev_better ? energy_mem[scan] : ev_energy;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (hb_reset)    state_nx = CLEAR;
        else if (accept) state_nx = SEARCH;
      end
      SEARCH: begin
        if (hb_reset)                 state_nx = CLEAR;
        else if (hit_now || last_now) state_nx = WRITE;
      end
      WRITE:   state_nx = hb_reset ? CLEAR : IDLE;
      CLEAR:   state_nx = hb_reset ? CLEAR : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_mem[i]     <= '0;
        hops_mem[i]   <= '0;
        qvalue_mem[i] <= '0;
        energy_mem[i] <= '0;
        chhops_mem[i] <= '0;
      end
      valid      <= '0;
      count      <= '0;
      wr_done    <= 1'b0;
      wr_drop    <= 1'b0;
      lat_id     <= '0;
      lat_hops   <= '0;
      lat_qvalue <= '0;
      lat_energy <= '0;
      lat_chhops <= '0;
      scan       <= '0;
      sel        <= '0;
      sel_insert <= 1'b0;
      sel_drop   <= 1'b0;
      free_found <= 1'b0;
      free_idx   <= '0;
`ifdef NEIGHBOR_EVICT_EN
      ev_found   <= 1'b0;
      ev_idx     <= '0;
      ev_energy  <= '0;
`endif
    end else begin
      wr_done <= 1'b0;
      wr_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (!hb_reset && accept) begin
            lat_id     <= node_id;
            lat_hops   <= node_hops;
            lat_qvalue <= node_qvalue;
            lat_energy <= node_energy;
            lat_chhops <= node_chhops;
            scan       <= '0;
            free_found <= 1'b0;
`ifdef NEIGHBOR_EVICT_EN
            ev_found   <= 1'b0;
`endif
          end
        end
        SEARCH: begin
          if (!hb_reset) begin
            scan       <= scan + AW'(1);
            free_found <= nxt_free_found;
            free_idx   <= nxt_free_idx;
`ifdef NEIGHBOR_EVICT_EN
            ev_found   <= ev_found | valid[scan];
            ev_idx     <= nxt_ev_idx;
            ev_energy  <= nxt_ev_energy;
`endif
            if (hit_now) begin
              sel        <= scan;
              sel_insert <= 1'b0;
              sel_drop   <= 1'b0;
            end else if (last_now) begin
              if (nxt_free_found) begin
                sel        <= nxt_free_idx;
                sel_insert <= 1'b1;
                sel_drop   <= 1'b0;
              end else begin
`ifdef NEIGHBOR_EVICT_EN
                sel        <= nxt_ev_idx;
                sel_insert <= 1'b0;
                sel_drop   <= 1'b0;
`else
                sel_insert <= 1'b0;
                sel_drop   <= 1'b1;
`endif
              end
            end
          end
        end
        WRITE: begin
          if (!hb_reset) begin
            if (sel_drop) begin
              wr_drop <= 1'b1;
            end else begin
              id_mem[sel]     <= lat_id;
              hops_mem[sel]   <= lat_hops;
              qvalue_mem[sel] <= lat_qvalue;
              energy_mem[sel] <= lat_energy;
              chhops_mem[sel] <= lat_chhops;
              valid[sel]      <= 1'b1;
              if (sel_insert) count <= count + CW'(1);
              wr_done <= 1'b1;
            end
          end
        end
        CLEAR: begin
          valid <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign full = (count == CW'(DEPTH));

  assign rd_valid  = valid[rd_idx];
  assign rd_id     = rd_valid ? id_mem[rd_idx]     : '0;
  assign rd_hops   = rd_valid ? hops_mem[rd_idx]   : '0;
  assign rd_qvalue = rd_valid ? qvalue_mem[rd_idx] : '0;
  assign rd_energy = rd_valid ? energy_mem[rd_idx] : '0;
  assign rd_chhops = rd_valid ? chhops_mem[rd_idx] : '0;

endmodule

// File: tb/tb_neighbor_cam_table.sv
// tb/tb_neighbor_cam_table.sv - scoreboard bench for neighbor_cam_table
module tb_neighbor_cam_table;

  localparam int W = 16;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic         hb_reset = 1'b0;
  logic [W-1:0] node_id = '0, node_hops = '0, node_qvalue = '0, node_energy = '0, node_chhops = '0;
  logic [4:0]   rd_idx = '0;
  logic [W-1:0] rd_id, rd_hops, rd_qvalue, rd_energy, rd_chhops;
  logic         rd_valid, busy, wr_done, wr_drop, full;
  logic [5:0]   count;

  neighbor_cam_table dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .hb_reset(hb_reset),
    .node_id(node_id), .node_hops(node_hops), .node_qvalue(node_qvalue),
    .node_energy(node_energy), .node_chhops(node_chhops), .rd_idx(rd_idx),
    .rd_id(rd_id), .rd_hops(rd_hops), .rd_qvalue(rd_qvalue),
    .rd_energy(rd_energy), .rd_chhops(rd_chhops), .rd_valid(rd_valid),
    .busy(busy), .wr_done(wr_done), .wr_drop(wr_drop), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic drop;
    int   lat;
  } exp_t;
  exp_t sb[$];

  int vectors = 0;
  int errors  = 0;

  logic         m_valid [D];
  logic [W-1:0] m_id [D], m_hops [D], m_q [D], m_e [D], m_ch [D];
  int           m_count = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear(input bit all);
    for (int i = 0; i < D; i++) begin
      m_valid[i] = 1'b0;
      if (all) begin
        m_id[i] = '0; m_hops[i] = '0; m_q[i] = '0; m_e[i] = '0; m_ch[i] = '0;
      end
    end
    m_count = 0;
  endtask

  task automatic check_entry(input int idx);
    rd_idx = 5'(idx);
    #1;
    chk("rd_valid",  rd_valid,  m_valid[idx]);
    chk("rd_id",     rd_id,     m_valid[idx] ? m_id[idx]   : 16'h0);
    chk("rd_hops",   rd_hops,   m_valid[idx] ? m_hops[idx] : 16'h0);
    chk("rd_qvalue", rd_qvalue, m_valid[idx] ? m_q[idx]    : 16'h0);
    chk("rd_energy", rd_energy, m_valid[idx] ? m_e[idx]    : 16'h0);
    chk("rd_chhops", rd_chhops, m_valid[idx] ? m_ch[idx]   : 16'h0);
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic do_write(input logic [W-1:0] id, h, q, e, c);
    int   hit, freei, tgt, cyc;
    bit   ins;
    exp_t x, y;
    node_id = id; node_hops = h; node_qvalue = q; node_energy = e; node_chhops = c;
    wr_en = 1'b1;
    if (id == 16'h000C) begin
      @(negedge clk);
      wr_en = 1'b0;
      repeat (3) begin
        chk("self_busy", busy, 1'b0);
        chk("self_pulse", {wr_done, wr_drop}, 2'b00);
        @(negedge clk);
      end
      chk("self_count", count, m_count);
      return;
    end
    hit = -1; freei = -1;
    for (int i = 0; i < D; i++) begin
      if (hit < 0 && m_valid[i] && m_id[i] == id) hit = i;
      if (freei < 0 && !m_valid[i]) freei = i;
    end
    ins = 0; tgt = -1;
    x.drop = 1'b0;
    if (hit >= 0) begin
      x.lat = hit + 2; tgt = hit;
    end else begin
      x.lat = D + 1;
      if (freei >= 0) begin
        tgt = freei; ins = 1;
      end else begin
`ifdef NEIGHBOR_EVICT_EN
        tgt = 0;
        for (int i = 1; i < D; i++) if (m_e[i] < m_e[tgt]) tgt = i;
`else
        x.drop = 1'b1;
`endif
      end
    end
    sb.push_back(x);
    @(negedge clk);
    wr_en = 1'b0;
    chk("busy_accept", busy, 1'b1);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (wr_done || wr_drop) break;
    end
    if (cyc >= 100) begin
      chk("pulse_timeout", 1'b0, 1'b1);
      void'(sb.pop_front());
      return;
    end
    y = sb.pop_front();
    chk("latency", cyc, y.lat);
    chk("wr_drop", wr_drop, y.drop);
    chk("wr_done", wr_done, !y.drop);
    if (tgt >= 0) begin
      m_valid[tgt] = 1'b1; m_id[tgt] = id; m_hops[tgt] = h;
      m_q[tgt] = q; m_e[tgt] = e; m_ch[tgt] = c;
      if (ins) m_count++;
      check_entry(tgt);
    end
    chk("count", count, m_count);
    @(negedge clk);
    chk("pulse_clear", {wr_done, wr_drop}, 2'b00);
    chk("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int nv;
    model_clear(1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 1'b0);
    chk("rst_pulses", {wr_done, wr_drop}, 2'b00);
    check_entry(0);

    do_write(16'h0003, 16'd1, 16'd7, 16'd50, 16'd2);
    do_write(16'h0003, 16'd5, 16'd8, 16'd51, 16'd3);
    do_write(16'h000C, 16'd9, 16'd9, 16'd9, 16'd9);
    check_entry(0);

    // Heartbeat clear from idle, then fill the table with distinct energies.
    hb_reset = 1'b1;
    @(negedge clk);
    hb_reset = 1'b0;
    @(negedge clk);
    model_clear(0);
    chk("hb_count", count, 0);
    for (int i = 0; i < D; i++)
      do_write(16'h0100 + 16'(i), 16'(i), 16'(2*i), 16'(100+i), 16'(i+1));
    chk("fill_full", full, 1'b1);
    do_write(16'h0050, 16'd4, 16'd4, 16'd200, 16'd4);
    check_entry(0);
    check_entry(D-1);
    chk("miss_count", count, D);

    // hb_reset in the middle of a search abandons the write.
    node_id = 16'h0060; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (4) @(negedge clk);
    hb_reset = 1'b1;
    @(negedge clk);
    hb_reset = 1'b0;
    chk("hb_clear_busy", busy, 1'b1);
    @(negedge clk);
    model_clear(0);
    chk("hb_mid_count", count, 0);
    chk("hb_mid_busy", busy, 1'b0);
    nv = 0;
    for (int i = 0; i < D; i++) begin
      rd_idx = 5'(i);
      #1;
      if (rd_valid) nv++;
    end
    chk("hb_valid_cnt", nv, 0);
    repeat (40) begin
      @(negedge clk);
      if (wr_done || wr_drop) break;
    end
    chk("hb_no_pulse", {wr_done, wr_drop}, 2'b00);

    // Reset asserted while the FSM sits in WRITE.
    do_write(16'h0070, 16'd3, 16'd3, 16'd3, 16'd3);
    node_id = 16'h0070; node_hops = 16'd6; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_count", count, 0);
    chk("rstw_done", wr_done, 1'b0);
    rd_idx = 5'd0;
    #1;
    chk("rstw_valid", rd_valid, 1'b0);
    chk("rstw_id", rd_id, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    model_clear(1);
    @(negedge clk);
    chk("post_rst_pulse", {wr_done, wr_drop}, 2'b00);
    check_entry(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
